// File: rtl/uart_port.sv
// uart_port: parametrised UART transceiver with TX/RX FIFOs and sticky receive error flags.
module uart_fifo #(
  parameter int W = 8,
  parameter int L = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2**L];
  logic [L:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q ^ rd_q) == {1'b1, {L{1'b0}}};
    do_pop = pop && !empty;
    do_push = push && (!full || pop);
    wr_d = wr_q + (L+1)'(do_push);
    rd_d = rd_q + (L+1)'(do_pop);
    rdata = empty ? '0 : mem_q[rd_q[L-1:0]];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[L-1:0]] <= wdata;
    end
  end
endmodule

module uart_port #(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 1,
  parameter int STOP_BITS = 1,
  parameter int SAMPLE_INTERVAL = 3,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 send_flag,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 recv_flag,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 sendable,
  output logic                 receivable,
  output logic                 tx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clear,
  output logic                 Tx,
  input  logic                 Rx
);
  localparam int CW = $clog2(SAMPLE_INTERVAL);
  typedef enum logic [1:0] {T_IDLE, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] baud_q, baud_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_head;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic tx_par_q, tx_par_d, tx_q, tx_d, stop_q, stop_d;
  logic rx1_q, rxs_q, rx_bad_q, rx_bad_d;
  logic pe_q, pe_d, fe_q, fe_d, oe_q, oe_d;
  logic tx_pop, tx_full, tx_empty, rx_push, rx_full, rx_empty;
  logic pe_set, fe_set, oe_set, sample;
  uart_fifo #(.W(DATA_BITS), .L(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .CLK(CLK), .RST(RST), .push(send_flag), .pop(tx_pop), .wdata(send_data),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );
  uart_fifo #(.W(DATA_BITS), .L(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .CLK(CLK), .RST(RST), .push(rx_push), .pop(recv_flag), .wdata(rx_shift_q),
    .rdata(recv_data), .full(rx_full), .empty(rx_empty)
  );
  assign sendable = !tx_full;
  assign receivable = !rx_empty;
  assign tx_busy = tx_state_q != T_IDLE;
  assign Tx = tx_q;
  assign parity_err = pe_q;
  assign frame_err = fe_q;
  assign overrun_err = oe_q;
  // TX only moves on baud ticks, so frames run back to back without idle gaps
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d = tx_bit_q;
    tx_par_d = tx_par_q;
    tx_d = tx_q;
    stop_d = stop_q;
    tx_pop = 1'b0;
    baud_d = baud_q == CW'(SAMPLE_INTERVAL - 1) ? '0 : baud_q + 1'b1;
    if (baud_q == '0) begin
      case (tx_state_q)
        T_IDLE: if (!tx_empty) begin
          tx_d = 1'b0;
          tx_shift_d = tx_head;
          tx_pop = 1'b1;
          tx_par_d = 1'b0;
          tx_bit_d = '0;
          tx_state_d = T_DATA;
        end
        T_DATA: begin
          tx_d = tx_shift_q[0];
          tx_par_d = tx_par_q ^ tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d = tx_bit_q + 3'd1;
          stop_d = 1'b0;
          if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = PARITY != 0 ? T_PAR : T_STOP;
        end
        T_PAR: begin
          tx_d = PARITY == 2 ? !tx_par_q : tx_par_q;
          tx_state_d = T_STOP;
        end
        T_STOP: begin
          tx_d = 1'b1;
          stop_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) tx_state_d = T_IDLE;
        end
      endcase
    end
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d = rx_bit_q;
    rx_bad_d = rx_bad_q;
    rx_push = 1'b0;
    pe_set = 1'b0;
    fe_set = 1'b0;
    oe_set = 1'b0;
    sample = rx_cnt_q == CW'(SAMPLE_INTERVAL / 2);
    rx_cnt_d = rx_cnt_q == CW'(SAMPLE_INTERVAL - 1) ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs_q) rx_state_d = R_START;
      end
      R_START: if (sample) begin
        rx_state_d = rxs_q ? R_IDLE : R_DATA;
        rx_bit_d = '0;
        rx_bad_d = 1'b0;
      end
      R_DATA: if (sample) begin
        rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = PARITY != 0 ? R_PAR : R_STOP;
      end
      R_PAR: if (sample) begin
        pe_set = rxs_q != ((^rx_shift_q) ^ (PARITY == 2));
        rx_bad_d = pe_set;
        rx_state_d = R_STOP;
      end
      R_STOP: if (sample) begin
        rx_state_d = R_IDLE;
        fe_set = !rxs_q;
        oe_set = rxs_q && !rx_bad_q && rx_full && !recv_flag;
        rx_push = rxs_q && !rx_bad_q && !oe_set;
      end
      default: rx_state_d = R_IDLE;
    endcase
    pe_d = (pe_q && !err_clear) || pe_set;
    fe_d = (fe_q && !err_clear) || fe_set;
    oe_d = (oe_q && !err_clear) || oe_set;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= T_IDLE;
      rx_state_q <= R_IDLE;
      baud_q <= '0;
      rx_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_par_q <= 1'b0;
      tx_q <= 1'b1;
      stop_q <= 1'b0;
      rx1_q <= 1'b1;
      rxs_q <= 1'b1;
      rx_bad_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      baud_q <= baud_d;
      rx_cnt_q <= rx_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_par_q <= tx_par_d;
      tx_q <= tx_d;
      stop_q <= stop_d;
      rx1_q <= Rx;
      rxs_q <= rx1_q;
      rx_bad_q <= rx_bad_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      oe_q <= oe_d;
    end
  end
endmodule
